// File: rtl/gpio_debounce_pkg.sv
// Shared defaults for the GPIO debouncer: pin count, counter widths, synchronizer depth.
package gpio_debounce_pkg;
  localparam int DEF_N      = 24;
  localparam int DEF_CW     = 8;
  localparam int DEF_SW     = 16;
  localparam int SYNC_DEPTH = 2;
endpackage

// File: rtl/gpio_debounce_cell.sv
// One debounced pin: optional 2-flop sync (GPIO_DEBOUNCE_SYNC_EN), stability counter, registered level/change.
// Latency sync depth + cfg_period ticks + 1 cycle; no backpressure, a change is accepted once stable long enough.
module gpio_debounce_cell
  import gpio_debounce_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_pin,
  input  logic          i_tick,
  input  logic [CW-1:0] i_period,
  output logic          o_pin,
  output logic          o_change
);

  logic          w_s;
  logic [CW-1:0] r_cnt;
  logic          r_pin;
  logic          r_change;
  logic [CW:0]   w_cnt_inc;
  logic          w_diff;
  logic          w_bypass;
  logic          w_accept;

`ifdef GPIO_DEBOUNCE_SYNC_EN
  logic [SYNC_DEPTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_DEPTH-2:0], i_pin};
    end
  end

  assign w_s = r_sync[SYNC_DEPTH-1];
`else
  assign w_s = i_pin;
`endif

  assign w_diff    = w_s ^ r_pin;
  assign w_bypass  = (i_period == '0);
  // One extra bit so the compare is exact even when cnt sits at its maximum.
  assign w_cnt_inc = {1'b0, r_cnt} + {{CW{1'b0}}, 1'b1};
  assign w_accept  = w_diff & (w_bypass | (i_tick & (w_cnt_inc >= {1'b0, i_period})));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_pin    <= 1'b0;
      r_change <= 1'b0;
    end else begin
      r_change <= w_accept;
      if (!w_diff || w_accept) begin
        r_cnt <= '0;
      end else if (i_tick) begin
        r_cnt <= w_cnt_inc[CW-1:0];
      end
      if (w_accept) begin
        r_pin <= w_s;
      end
    end
  end

  assign o_pin    = r_pin;
  assign o_change = r_change;

endmodule

// File: rtl/gpio_debounce.sv
// N-pin debouncer with one shared tick prescaler; define GPIO_DEBOUNCE_SYNC_EN to add a 2-flop input sync.
// Latency sync depth + up to (cfg_prescale+1)*max(cfg_period,1)+1 cycles; no backpressure.
module gpio_debounce
  import gpio_debounce_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int CW = DEF_CW,
  parameter int SW = DEF_SW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  pin_in,
  input  logic [SW-1:0] cfg_prescale,
  input  logic [CW-1:0] cfg_period,
  output logic [N-1:0]  pin_out,
  output logic [N-1:0]  change
);

  logic [SW-1:0] r_pcnt;
  logic          w_tick;

  // >= rather than == so lowering cfg_prescale mid-count ticks at once instead of wrapping.
  assign w_tick = (r_pcnt >= cfg_prescale);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcnt <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + {{(SW-1){1'b0}}, 1'b1};
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_cell
    gpio_debounce_cell #(
      .CW(CW)
    ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .i_pin    (pin_in[g]),
      .i_tick   (w_tick),
      .i_period (cfg_period),
      .o_pin    (pin_out[g]),
      .o_change (change[g])
    );
  end

endmodule
